i3_router_fifo_rdctrl: RTL
==========================

I3_ROUTER_FIFO_RDCTRL -- requirements
Module: i3_router_fifo_rdctrl

Interface
REQ-001 Parameter: DATA_W, default 32, flit width; bits [DATA_W-1:DATA_W-3] are the 3-bit flit type field.
REQ-002 Parameter: HEAD_T, default 3'b001, head flit type.
REQ-003 Parameter: TAIL_T, default 3'b110, tail flit type.
REQ-004 Port clk: input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, reset, synchronous, active-high.
REQ-006 Port FIFO_empty: input, 1 bit, high when the upstream show-ahead FIFO holds no flit.
REQ-007 Port FIFO_data: input, DATA_W bits, front flit of the FIFO; valid whenever FIFO_empty=0.
REQ-008 Port FIFO_rd: output, 1 bit, combinational pop strobe; the front flit is consumed on the edge where FIFO_rd=1.
REQ-009 Port output_req: output, 1 bit, output register holds a valid flit.
REQ-010 Port output_data: output, DATA_W bits, registered flit toward the downstream port.
REQ-011 Port output_head: output, 3 bits, type field of output_data.
REQ-012 Port output_bussy: input, 1 bit, downstream busy; a flit is accepted on any edge with output_req=1 and output_bussy=0.
REQ-013 Port pkt_active: output, 1 bit, high in state PKT.
REQ-014 Port frame_err: output, 1 bit, one-cycle registered pulse on a framing error.
REQ-015 Port drop_cnt: output, 8 bits, count of discarded flits; saturates at 255.
REQ-016 Port pkt_cnt: output, 16 bits, count of tails accepted downstream; wraps 65535->0.

Function
REQ-017 States: IDLE (search for head) and PKT (forward body/tail); encoding 1 bit.
REQ-018 The output register SHALL be free when output_req=0, or when output_req=1 and output_bussy=0 in the same cycle.
REQ-019 IDLE, FIFO non-empty, front type != HEAD_T: FIFO_rd=1 regardless of register state; flit discarded; drop_cnt +1 (saturating).
REQ-020 IDLE, front type == HEAD_T, register free: FIFO_rd=1; flit loads into the register; next state PKT.
REQ-021 PKT, FIFO non-empty, register free: FIFO_rd=1; flit loads; if its type == TAIL_T, next state IDLE.
REQ-022 PKT, front type == HEAD_T (missing tail): flit forwarded as a new packet start; frame_err pulses next cycle; state stays PKT.
REQ-023 Latency: FIFO non-empty and register empty at edge N -> output_req=1 after edge N (1 cycle).
REQ-024 Throughput: 1 flit/cycle while output_bussy=0 and FIFO non-empty; simultaneous accept and load allowed.
REQ-025 output_data and output_head SHALL hold stable while output_req=1 and output_bussy=1.
REQ-026 FIFO_rd SHALL be 0 when FIFO_empty=1 or rst=1.
REQ-027 A head followed directly by a tail forms a legal 2-flit packet; a head+tail-in-one flit does not exist.
REQ-028 pkt_cnt increments on acceptance of a flit with output_head == TAIL_T.

Reset
REQ-029 With rst=1 at an edge: state IDLE; output_req=0; output_data=0; output_head=0; frame_err=0; drop_cnt=0; pkt_cnt=0.
REQ-030 Reset mid-packet: the held flit is dropped without handshake; the FIFO is not popped; after release, non-head flits are discarded until the next head.

Structure
REQ-031 Shared router package: flit type constants (HEAD_T=3'b001, TAIL_T=3'b110) and the type-field slice position, also used by the write controller.
REQ-032 Single module; no sub-module.

Verification
REQ-033 Reset, then 4-flit packet 001,000,000,110 with output_bussy=0 -> output_head sequence 001,000,000,110 on 4 consecutive cycles starting 1 cycle after the first flit appears; pkt_cnt=1.
REQ-034 Flits 000,110 then 001,110 in FIFO -> drop_cnt=2; output shows only 001,110.
REQ-035 output_bussy=1 for 5 cycles after head loads -> output_data stable; FIFO_rd=0 those cycles; 001 accepted on first bussy=0 cycle.
REQ-036 001,000,001,110 -> frame_err one pulse after the second 001 loads; all 4 flits forwarded; pkt_cnt=1.
REQ-037 rst=1 for 1 cycle while 000 is held -> output_req=0 next cycle; following 000,110 dropped (drop_cnt=2).
REQ-038 300 non-head flits -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/i3_router_pkg.sv
// Shared router definitions: flit type codes and the position of the type
// field inside a flit. Both FIFO controllers of the router import this.
package i3_router_pkg;

   localparam int TYPE_W = 3;

   localparam logic [TYPE_W-1:0] HEAD_FLIT = 3'b001;
   localparam logic [TYPE_W-1:0] BODY_FLIT = 3'b000;
   localparam logic [TYPE_W-1:0] TAIL_FLIT = 3'b110;

   // The type field occupies the top TYPE_W bits of every flit.
   function automatic int type_lsb(input int data_w);
      return data_w - TYPE_W;
   endfunction

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_PKT  = 1'b1
   } rd_state_t;

endpackage

// File: rtl/i3_router_fifo_rdctrl.sv
// Router FIFO read controller. Pulls flits from a show-ahead FIFO, throws
// away anything that is not part of a framed packet, and forwards packet
// flits through a single output register with a req/busy handshake.
module i3_router_fifo_rdctrl
   import i3_router_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter logic [TYPE_W-1:0] HEAD_T = HEAD_FLIT,
   parameter logic [TYPE_W-1:0] TAIL_T = TAIL_FLIT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              FIFO_empty,
   input  logic [DATA_W-1:0] FIFO_data,
   output logic              FIFO_rd,
   output logic              output_req,
   output logic [DATA_W-1:0] output_data,
   output logic [2:0]        output_head,
   input  logic              output_bussy,
   output logic              pkt_active,
   output logic              frame_err,
   output logic [7:0]        drop_cnt,
   output logic [15:0]       pkt_cnt
);

   localparam int TLSB = DATA_W - TYPE_W;

   rd_state_t         state;
   logic [TYPE_W-1:0] front_type;
   logic              front_head;
   logic              reg_free;
   logic              accept;
   logic              load;
   logic              drop;

   assign front_type = FIFO_data[DATA_W-1:TLSB];
   assign front_head = (front_type == HEAD_T);
   assign accept     = output_req & ~output_bussy;
   assign reg_free   = ~output_req | ~output_bussy;
   assign pkt_active = (state == RD_PKT);

   // Pop decision: junk is popped and dropped whenever we are hunting for a
   // head; packet flits are popped only when the output register can take them.
   always_comb begin
      FIFO_rd = 1'b0;
      load    = 1'b0;
      drop    = 1'b0;
      if (!rst && !FIFO_empty) begin
         if (state == RD_IDLE) begin
            if (!front_head) begin
               FIFO_rd = 1'b1;
               drop    = 1'b1;
            end else if (reg_free) begin
               FIFO_rd = 1'b1;
               load    = 1'b1;
            end
         end else if (reg_free) begin
            FIFO_rd = 1'b1;
            load    = 1'b1;
         end
      end
   end

   // Framing FSM, output register, error pulse and statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RD_IDLE;
         output_req  <= 1'b0;
         output_data <= '0;
         output_head <= '0;
         frame_err   <= 1'b0;
         drop_cnt    <= '0;
         pkt_cnt     <= '0;
      end else begin
         frame_err <= 1'b0;

         if (accept && output_head == TAIL_T)
            pkt_cnt <= pkt_cnt + 16'd1;

         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         if (load) begin
            output_req  <= 1'b1;
            output_data <= FIFO_data;
            output_head <= front_type;
         end else if (accept) begin
            output_req  <= 1'b0;
         end

         case (state)
            RD_IDLE: begin
               if (load)
                  state <= RD_PKT;
            end
            RD_PKT: begin
               if (load) begin
                  if (front_type == TAIL_T)
                     state <= RD_IDLE;
                  else if (front_head)
                     frame_err <= 1'b1;
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

endmodule
